// File: rtl/sram_rd_pkg.sv
// Shared types and default widths for the SRAM burst read front end.
package sram_rd_pkg;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;
endpackage

// File: rtl/sram_rd_fifo2.sv
// Two-entry output FIFO of {data, last}; the head register drives the stream directly.
module sram_rd_fifo2
    import sram_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              head_valid,
    output logic [1:0]        occ
);
    logic [DATA_W-1:0] tail_data;
    logic              tail_last;
    logic [1:0]        cnt;

    // Head/tail shift structure: a pop at depth 2 moves the tail forward.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
            cnt       <= 2'd0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push) begin
                        head_data <= push_data;
                        head_last <= push_last;
                        cnt       <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else if (push) begin
                        tail_data <= push_data;
                        tail_last <= push_last;
                        cnt       <= 2'd2;
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        if (push) begin
                            tail_data <= push_data;
                            tail_last <= push_last;
                        end else begin
                            cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign head_valid = (cnt != 2'd0);
    assign occ        = cnt;
endmodule

// File: rtl/sram_burst_reader.sv
// Burst read front end for the 2048x32 single-port SRAM with a valid/ready output stream.
// Optional feature: define SRAM_RD_ABORT_EN to add the abort input.
module sram_burst_reader
    import sram_rd_pkg::*;
#(
    parameter int NUM_WORD = 2048,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              CEB,
    output logic              WEB,
    output logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Q,
`ifdef SRAM_RD_ABORT_EN
    input  logic              abort,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    rd_state_t         state, state_nx;
    logic [ADDR_W-1:0] addr_cnt, addr_nx, last_a;
    logic [LEN_W-1:0]  rem_cnt;
    logic              inflight, inflight_last, done_q;
    logic              issue, pop, cmd_fire, finish, abort_hit, fifo_clr_n;
    logic [1:0]        occ;

`ifdef SRAM_RD_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign pop      = out_valid && out_ready;
    assign cmd_fire = (state == IDLE) && cmd_valid && (cmd_len != '0);
    assign addr_nx  = (addr_cnt == ADDR_W'(NUM_WORD - 1)) ? '0 : addr_cnt + 1'b1;
    assign finish   = ((state == IDLE) && cmd_valid && (cmd_len == '0))
                    || ((state == DRAIN) && !out_valid && !inflight)
                    || abort_hit;

    always_ff @(posedge CLK) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_fire) state_nx = BURST;
            BURST: begin
                if (abort_hit)                            state_nx = IDLE;
                else if (issue && (rem_cnt == LEN_W'(1))) state_nx = DRAIN;
            end
            DRAIN:   if (finish) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A read may issue only if the word it returns is guaranteed a FIFO slot.
    always_comb begin
        issue = 1'b0;
        if ((state == BURST) && !abort_hit)
            issue = (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
        CEB       = !issue;
        WEB       = 1'b1;
        A         = issue ? addr_cnt : last_a;
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = done_q;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            addr_cnt      <= '0;
            rem_cnt       <= '0;
            last_a        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (rem_cnt == LEN_W'(1));
            done_q        <= finish;
            if (cmd_fire) begin
                addr_cnt <= cmd_addr;
                rem_cnt  <= cmd_len;
            end else if (issue) begin
                addr_cnt <= addr_nx;
                rem_cnt  <= rem_cnt - 1'b1;
                last_a   <= addr_cnt;
            end
        end
    end

    assign fifo_clr_n = RSTN && !abort_hit;

    sram_rd_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk        (CLK),
        .clr_n      (fifo_clr_n),
        .push       (inflight),
        .push_data  (Q),
        .push_last  (inflight_last),
        .pop        (pop),
        .head_data  (out_data),
        .head_last  (out_last),
        .head_valid (out_valid),
        .occ        (occ)
    );
endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader with a behavioural 2048x32 SRAM holding word[i]=i.
module tb_sram_burst_reader;
    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_addr = '0;
    logic [11:0] cmd_len = '0;
    logic        CEB, WEB;
    logic [10:0] A;
    logic [31:0] Q = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy, done;
`ifdef SRAM_RD_ABORT_EN
    logic        abort = 1'b0;
`endif

    sram_burst_reader dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .CEB       (CEB),
        .WEB       (WEB),
        .A         (A),
        .Q         (Q),
`ifdef SRAM_RD_ABORT_EN
        .abort     (abort),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [0:2047];
    always @(posedge CLK) if (!CEB) Q <= mem[A];

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Stream monitor, sampled on the falling edge.
    logic [31:0] dq[$];
    logic        lq[$];
    int          pc[$];
    logic [10:0] aq[$];
    int cyc = 0, done_cnt = 0, pend = 0, max_pend = 0, ceb_viol = 0, stab_viol = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] hold_d;
    logic        hold_l;

    always @(negedge CLK) begin
        cyc++;
        if (done) done_cnt++;
        if (!CEB) aq.push_back(A);
        if (pend > max_pend) max_pend = pend;
        if (pend >= 2 && !(out_valid && out_ready) && !CEB) ceb_viol++;
        if (stall_prev && (!out_valid || out_data !== hold_d || out_last !== hold_l)) stab_viol++;
        stall_prev = out_valid && !out_ready;
        hold_d = out_data;
        hold_l = out_last;
        if (out_valid && out_ready) begin
            dq.push_back(out_data);
            lq.push_back(out_last);
            pc.push_back(cyc);
        end
        pend = pend + (CEB ? 0 : 1) - ((out_valid && out_ready) ? 1 : 0);
        if (!RSTN) begin
            pend = 0;
            stall_prev = 1'b0;
        end
    end

    task automatic clr_mon();
        dq.delete(); lq.delete(); pc.delete(); aq.delete();
        done_cnt = 0; max_pend = 0; ceb_viol = 0; stab_viol = 0;
    endtask

    int          hs_cyc;
    logic [15:0] bp_pat = 16'b1101_0110_0000_1011;

    task automatic send_cmd(input int addr, input int len);
        int n;
        @(negedge CLK);
        cmd_addr  = 11'(addr);
        cmd_len   = 12'(len);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        #1 hs_cyc = cyc;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit bp);
        for (int k = 0; k < budget; k++) begin
            @(posedge CLK);
            #1;
            if (bp) out_ready = bp_pat[k % 16];
            @(negedge CLK);
            if (done) break;
        end
        #1;
        chk(tag, done, 1);
        out_ready = 1'b1;
    endtask

    task automatic chk_burst(input string tag, input int addr, input int len);
        int bad, nlast;
        bad = 0;
        nlast = 0;
        chk({tag, "_count"}, dq.size(), len);
        for (int i = 0; i < dq.size(); i++) begin
            if (dq[i] !== 32'((addr + i) % 2048)) bad++;
            if (lq[i]) nlast++;
        end
        chk({tag, "_data_bad"}, bad, 0);
        chk({tag, "_nlast"}, nlast, 1);
        if (lq.size() > 0) chk({tag, "_last_on_final"}, lq[lq.size()-1], 1);
        chk({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'(i);

        // Reset values
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_ceb", CEB, 1);
        chk("rst_web", WEB, 1);
        chk("rst_a", A, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge CLK);
        #1 RSTN = 1'b1;

        // Zero-length command: done next cycle, no read
        clr_mon();
        send_cmd(5, 0);
        @(negedge CLK);
        #1;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        @(negedge CLK);
        #1;
        chk("len0_done_drop", done, 0);
        chk("len0_no_read", aq.size(), 0);

        // Basic 4-word burst
        clr_mon();
        send_cmd(10, 4);
        wait_done("b4_done", 50, 1'b0);
        chk_burst("b4", 10, 4);
        if (dq.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("b4_word", dq[i], 32'(10 + i));
            chk("b4_first_latency", pc[0] - hs_cyc, 3);
            chk("b4_consecutive", pc[3] - pc[0], 3);
        end
        chk("b4_issue_cnt", aq.size(), 4);

        // Address wrap
        clr_mon();
        send_cmd(2046, 4);
        wait_done("wrap_done", 50, 1'b0);
        chk_burst("wrap", 2046, 4);
        if (aq.size() == 4) begin
            chk("wrap_a0", aq[0], 2046);
            chk("wrap_a1", aq[1], 2047);
            chk("wrap_a2", aq[2], 0);
            chk("wrap_a3", aq[3], 1);
        end
        chk("wrap_issue_cnt", aq.size(), 4);

        // Backpressure
        clr_mon();
        send_cmd(100, 8);
        wait_done("bp_done", 300, 1'b1);
        chk_burst("bp", 100, 8);
        chk("bp_max_buffered_le2", (max_pend <= 2) ? 1 : 0, 1);
        chk("bp_max_buffered_hit2", max_pend, 2);
        chk("bp_ceb_while_full", ceb_viol, 0);
        chk("bp_stall_stable", stab_viol, 0);
        chk("bp_issue_cnt", aq.size(), 8);

        // Full-depth burst
        clr_mon();
        send_cmd(0, 2048);
        wait_done("full_done", 2200, 1'b0);
        chk_burst("full", 0, 2048);
        if (pc.size() == 2048) chk("full_consecutive", pc[2047] - pc[0], 2047);

        // Reset mid-burst
        clr_mon();
        out_ready = 1'b0;
        send_cmd(200, 8);
        repeat (4) @(posedge CLK);
        #1 RSTN = 1'b0;
        @(posedge CLK);
        #1 RSTN = 1'b1;
        @(negedge CLK);
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_cmd_ready", cmd_ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_ceb", CEB, 1);
        out_ready = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        chk("mrst_no_done", done_cnt, 0);
        clr_mon();
        send_cmd(300, 3);
        wait_done("mrst_new_done", 50, 1'b0);
        chk_burst("mrst_new", 300, 3);

`ifdef SRAM_RD_ABORT_EN
        // Abort mid-burst
        clr_mon();
        out_ready = 1'b0;
        send_cmd(400, 8);
        repeat (4) @(posedge CLK);
        #1 abort = 1'b1;
        @(posedge CLK);
        #1 abort = 1'b0;
        @(negedge CLK);
        #1;
        pend = 0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_done", done, 1);
        out_ready = 1'b1;
        clr_mon();
        send_cmd(500, 5);
        wait_done("abort_new_done", 50, 1'b0);
        chk_burst("abort_new", 500, 5);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
